// File: rtl/jtcolmix_palrd.sv
// Palette read and colour stage. Each pixel's 16-bit palette word is fetched from byte-wide RAM.
// The word is expanded to 8 bits per channel, shaded or highlighted, then presented one pixel later.
module jtcolmix_palrd #(
  parameter bit SHADOW_EN  = 1'b1,
  parameter bit BLANK_ZERO = 1'b1
) (
  input  logic        i_rst,
  input  logic        i_clk,
  input  logic        i_pxl_cen,
  input  logic        i_lhbl,
  input  logic        i_lvbl,
  input  logic [10:0] i_pal_idx,
  input  logic        i_col_n,
  input  logic [1:0]  i_shd,
  input  logic        i_brit,
  output logic [11:0] o_pal_addr,
  input  logic [7:0]  i_pal_dout,
  output logic [7:0]  o_red,
  output logic [7:0]  o_green,
  output logic [7:0]  o_blue,
  output logic        o_lhbl_dly,
  output logic        o_lvbl_dly,
  output logic [2:0]  o_dbg_st,
  output logic        o_dbg_valid
);

  logic [10:0] r_idx;
  logic        r_col_n;
  logic [1:0]  r_shd;
  logic        r_brit;
  logic        r_lhbl;
  logic        r_lvbl;
  logic        r_armed;
  logic        r_valid;
  logic [2:0]  r_st;
  logic [7:0]  r_lo;
  logic [7:0]  r_hi;
  logic [23:0] r_hold;

  logic [10:0] w_idx;
  logic        w_shadow;
  logic        w_hilite;
  logic        w_new;
  logic        w_blank;
  logic [23:0] w_proc;
  logic [23:0] w_col;

  function automatic logic [7:0] f_chan(input logic [4:0] c, input logic sh, input logic hl);
    logic [7:0] c8;
    c8 = {c, c[4:2]};
    if (sh)      f_chan = c8 >> 1;
    else if (hl) f_chan = c8 + ((~c8) >> 1);
    else         f_chan = c8;
  endfunction

  assign w_idx      = r_col_n ? 11'd0 : r_idx;
  // Address stays on the odd byte for every step past 0, so late passes never re-touch RAM.
  assign o_pal_addr = {w_idx, r_st != 3'd0};
  assign w_shadow   = SHADOW_EN && (r_shd != 2'b11);
  assign w_hilite   = SHADOW_EN && (r_shd == 2'b11) && r_brit;
  assign w_new      = r_valid && (r_st == 3'd3);
  assign w_blank    = BLANK_ZERO && !(r_lhbl && r_lvbl);
  assign o_dbg_st   = r_st;
  assign o_dbg_valid = r_valid;

  always_comb begin
    w_proc = {f_chan(r_lo[4:0], w_shadow, w_hilite),
              f_chan({r_hi[1:0], r_lo[7:5]}, w_shadow, w_hilite),
              f_chan(r_hi[6:2], w_shadow, w_hilite)};
    // A pixel edge landing on the compute step still gets this pixel's colour.
    w_col  = w_new ? w_proc : r_hold;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_idx      <= '0;
      r_col_n    <= 1'b0;
      r_shd      <= '0;
      r_brit     <= 1'b0;
      r_lhbl     <= 1'b0;
      r_lvbl     <= 1'b0;
      r_armed    <= 1'b0;
      r_valid    <= 1'b0;
      r_st       <= '0;
      r_lo       <= '0;
      r_hi       <= '0;
      r_hold     <= '0;
      o_red      <= '0;
      o_green    <= '0;
      o_blue     <= '0;
      o_lhbl_dly <= 1'b0;
      o_lvbl_dly <= 1'b0;
    end else begin
      if (i_pxl_cen) begin
        r_idx   <= i_pal_idx;
        r_col_n <= i_col_n;
        r_shd   <= i_shd;
        r_brit  <= i_brit;
        r_lhbl  <= i_lhbl;
        r_lvbl  <= i_lvbl;
        r_armed <= 1'b1;
        r_valid <= 1'b0;
        r_st    <= '0;
      end else begin
        if (r_st != 3'd7) r_st <= r_st + 3'd1;
        if (r_armed && r_st == 3'd1) r_lo <= i_pal_dout;
        if (r_armed && r_st == 3'd2) begin
          r_hi    <= i_pal_dout;
          r_valid <= 1'b1;
        end
      end
      if (w_new) r_hold <= w_proc;
      if (i_pxl_cen) begin
        {o_red, o_green, o_blue} <= w_blank ? 24'd0 : w_col;
        o_lhbl_dly <= r_lhbl;
        o_lvbl_dly <= r_lvbl;
      end
    end
  end

endmodule

// File: tb/tb_jtcolmix_palrd.sv
// Bench for jtcolmix_palrd: directed and random pixels against a behavioural colour model.
// The model keeps a byte RAM image and one held colour per pixel.
module tb_jtcolmix_palrd;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pxl_cen = 1'b0;
  logic        lhbl = 1'b1;
  logic        lvbl = 1'b1;
  logic [10:0] pal_idx = '0;
  logic        col_n = 1'b0;
  logic [1:0]  shd = 2'b11;
  logic        brit = 1'b0;
  logic [7:0]  pal_dout = '0;
  logic [11:0] pal_addr;
  logic [7:0]  red, green, blue;
  logic        lhbl_dly, lvbl_dly;
  logic [2:0]  dbg_st;
  logic        dbg_valid;

  jtcolmix_palrd dut (
    .i_rst(rst), .i_clk(clk), .i_pxl_cen(pxl_cen), .i_lhbl(lhbl), .i_lvbl(lvbl),
    .i_pal_idx(pal_idx), .i_col_n(col_n), .i_shd(shd), .i_brit(brit),
    .o_pal_addr(pal_addr), .i_pal_dout(pal_dout),
    .o_red(red), .o_green(green), .o_blue(blue),
    .o_lhbl_dly(lhbl_dly), .o_lvbl_dly(lvbl_dly),
    .o_dbg_st(dbg_st), .o_dbg_valid(dbg_valid)
  );

  // clock / RAM
  always #5 clk = ~clk;

  logic [7:0] ram [0:4095];
  always @(posedge clk) pal_dout <= ram[pal_addr];

  int n_chk = 0;
  int n_pass = 0;
  logic [25:0] exp_q[$];

  // model state: the pixel latched at the previous edge and the colour on hold
  logic [10:0] m_idx;
  logic        m_col_n, m_brit, m_lh, m_lv, m_have;
  logic [1:0]  m_shd;
  int          m_sp;
  logic [23:0] m_held;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [7:0] ref_chan(input int c5, input int mode);
    int c8;
    c8 = c5 * 8 + c5 / 4;
    if (mode == 1)      c8 = c8 / 2;
    else if (mode == 2) c8 = c8 + (255 - c8) / 2;
    return 8'(c8);
  endfunction

  function automatic logic [23:0] ref_colour();
    int e, word, mode;
    e    = m_col_n ? 0 : int'(m_idx);
    word = int'(ram[2*e+1]) * 256 + int'(ram[2*e]);
    mode = (m_shd != 2'b11) ? 1 : (m_brit ? 2 : 0);
    return {ref_chan(word % 32, mode), ref_chan((word / 32) % 32, mode),
            ref_chan((word / 1024) % 32, mode)};
  endfunction

  task automatic model_reset();
    m_have = 1'b0; m_held = '0; m_lh = 1'b0; m_lv = 1'b0; m_sp = 0;
    m_idx = '0; m_col_n = 1'b0; m_shd = '0; m_brit = 1'b0;
    exp_q.delete();
  endtask

  // driver: one pixel edge, then sp clocks until the next one
  task automatic pixel(input logic [10:0] idx, input logic cn, input logic [1:0] sh,
                       input logic br, input logic lh, input logic lv, input int sp);
    logic [11:0] ea;
    logic [23:0] e;
    if (m_have && m_sp >= 4) m_held = ref_colour();
    e = (m_lh && m_lv) ? m_held : 24'd0;
    exp_q.push_back({e, m_lh, m_lv});
    m_idx = idx; m_col_n = cn; m_shd = sh; m_brit = br; m_lh = lh; m_lv = lv;
    m_sp = sp; m_have = 1'b1;
    pal_idx = idx; col_n = cn; shd = sh; brit = br; lhbl = lh; lvbl = lv;
    pxl_cen = 1'b1;
    @(negedge clk);
    pxl_cen = 1'b0;
    ea = {(cn ? 11'd0 : idx), 1'b0};
    check("addr_even", 32'(pal_addr), 32'(ea));
    if (sp >= 2) begin
      @(negedge clk);
      check("addr_odd", 32'(pal_addr), 32'(ea | 12'd1));
    end
    for (int k = 2; k < sp; k++) @(negedge clk);
  endtask

  // monitor: every pixel edge presents one output word
  initial begin
    logic [25:0] e;
    forever begin
      @(posedge clk);
      if (pxl_cen && !rst) begin
        #1;
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL pixel_out: got output with no expectation queued at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          check("pixel_out", 32'({red, green, blue, lhbl_dly, lvbl_dly}), 32'(e));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < 4096; a++) ram[a] = 8'($urandom);
    ram[12'h246] = 8'h1F; ram[12'h247] = 8'h00;
    ram[12'h010] = 8'h02; ram[12'h011] = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_rgb", 32'({red, green, blue}), 32'd0);
    check("rst_blank", 32'({lhbl_dly, lvbl_dly}), 32'd0);
    check("rst_addr", 32'(pal_addr), 32'd0);
    check("rst_state", 32'({dbg_st, dbg_valid}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    pixel(11'h123, 1'b0, 2'b11, 1'b0, 1'b1, 1'b1, 6);
    pixel(11'h123, 1'b0, 2'b01, 1'b0, 1'b1, 1'b1, 6);
    pixel(11'h123, 1'b0, 2'b01, 1'b1, 1'b1, 1'b1, 6);
    pixel(11'h008, 1'b0, 2'b11, 1'b1, 1'b1, 1'b1, 6);
    pixel(11'h555, 1'b1, 2'b11, 1'b0, 1'b1, 1'b1, 6);
    pixel(11'h123, 1'b0, 2'b11, 1'b0, 1'b0, 1'b1, 6);
    pixel(11'h123, 1'b0, 2'b11, 1'b0, 1'b1, 1'b1, 3);
    pixel(11'h008, 1'b0, 2'b11, 1'b1, 1'b1, 1'b1, 3);
    pixel(11'h123, 1'b0, 2'b11, 1'b0, 1'b1, 1'b1, 6);
    pixel(11'h008, 1'b0, 2'b11, 1'b1, 1'b1, 1'b1, 2);

    // abort mid-fetch; red is non-zero at this point
    rst = 1'b1;
    #1;
    check("async_rst_rgb", 32'({red, green, blue}), 32'd0);
    check("async_rst_misc", 32'({lhbl_dly, lvbl_dly, pal_addr, dbg_st}), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    pixel(11'h123, 1'b0, 2'b11, 1'b0, 1'b1, 1'b1, 6);
    pixel(11'h555, 1'b0, 2'b11, 1'b0, 1'b1, 1'b1, 6);

    for (int n = 0; n < 300; n++) begin
      pixel(11'($urandom), ($urandom_range(0, 7) == 0), 2'($urandom), 1'($urandom),
            ($urandom_range(0, 9) != 0), ($urandom_range(0, 9) != 0),
            int'($urandom_range(3, 8)));
    end
    repeat (4) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/jtcolmix_palrd.md
JTCOLMIX_PALRD -- requirements
Module: jtcolmix_palrd

Interface
REQ-001 Parameter SHADOW_EN, default 1: 1 enables the shadow/highlight arithmetic; 0 passes the expanded colour unchanged.
REQ-002 Parameter BLANK_ZERO, default 1: 1 forces RGB to 0 during blanking; 0 passes the colour through during blanking.
REQ-003 rst  input  1  Reset; asynchronous, active-high.
REQ-004 clk  input  1  Single clock; all state is on its rising edge.
REQ-005 pxl_cen  input  1  Pixel clock enable, one clk wide.
REQ-006 lhbl, lvbl  input  1 each  Horizontal and vertical blanking, active-low, from the video timing.
REQ-007 pal_idx  input  11  Palette index from the priority mixer.
REQ-008 col_n  input  1  1 means the mixer output is transparent, so the backdrop is used.
REQ-009 shd  input  2  Mixer shadow output; 2'b11 means no shadow, any other value means shadow.
REQ-010 brit  input  1  Highlight request from the mixer.
REQ-011 pal_addr  output  12  Byte address to the external palette RAM.
REQ-012 pal_dout  input  8  Palette RAM read data; valid exactly 1 clk after pal_addr.
REQ-013 red, green, blue  output  8 each  Final pixel colour, registered.
REQ-014 lhbl_dly, lvbl_dly  output  1 each  lhbl and lvbl delayed to align with RGB.

Function
REQ-015 On each pxl_cen the block SHALL latch pal_idx, col_n, shd, brit, lhbl and lvbl, and SHALL clear the step counter st to 0.
REQ-016 st SHALL increment on every clk that has no pxl_cen and SHALL saturate at 7.
REQ-017 The effective index SHALL be 0 when the latched col_n is 1; otherwise it SHALL be the latched pal_idx.
REQ-018 Fetch at st==0: pal_addr SHALL be {idx,1'b0}.
REQ-019 Fetch at st==1: pal_addr SHALL be {idx,1'b1}, and the low byte SHALL be captured from pal_dout.
REQ-020 Fetch at st==2: the high byte SHALL be captured, and a valid flag SHALL be set.
REQ-021 The valid flag SHALL be cleared at every pxl_cen.
REQ-022 Word format: low byte = {G[2:0],R[4:0]}; high byte = {x,B[4:0],G[4:3]}; bit 7 of the high byte SHALL be ignored.
REQ-023 5-to-8 bit expansion of each channel c SHALL be {c,c[4:2]}.
REQ-024 Shadow SHALL apply when SHADOW_EN=1 and shd!=2'b11: each channel becomes c8>>1.
REQ-025 Highlight SHALL apply when SHADOW_EN=1, shd==2'b11 and brit=1: each channel becomes c8+((~c8)>>1); this cannot overflow 8 bits.
REQ-026 When shadow and brit are both active, shadow SHALL win.
REQ-027 Processed RGB SHALL be computed at st==3 into a holding register.
REQ-028 Output timing: red/green/blue, lhbl_dly and lvbl_dly SHALL update only on pxl_cen, from the holding register and the latched blanking bits. Latency is exactly one pixel: data latched at pxl_cen N appears at pxl_cen N+1.
REQ-029 When BLANK_ZERO=1 and the latched lhbl or lvbl is 0, RGB output SHALL be 0.
REQ-030 Short pixel period: if pxl_cen arrives before the valid flag is set (fewer than 4 clk since the last pxl_cen), the holding register SHALL keep its previous colour, and no partial word SHALL reach the output.
REQ-031 Late or multiple passes: pal_addr SHALL hold {idx,1'b1} for all st>=1, and captures SHALL happen only at st 1 and 2, so no repeated RAM side effects occur.
REQ-032 Simultaneous pxl_cen and st==2: pxl_cen SHALL take priority; the capture is discarded and valid stays 0.

Reset
REQ-033 While rst is high, the following SHALL be 0: red, green, blue, lhbl_dly, lvbl_dly, pal_addr, st, the valid flag, the holding register and all latched inputs.
REQ-034 Reset asserted mid-fetch SHALL abort the fetch immediately.
REQ-035 After reset release, the first output update SHALL occur at the second pxl_cen; the first pxl_cen outputs 0 colour.

Verification
REQ-036 Basic fetch: pxl_cen every 6 clk, pal_idx=0x123, col_n=0, shd=3, brit=0, RAM[0x246]=0x1F, RAM[0x247]=0x00, blanking inactive -> pal_addr shows 0x246 then 0x247; next pxl_cen gives RGB=FF,00,00.
REQ-037 Shadow: same stimulus with shd=2'b01 -> RGB=7F,00,00. Same stimulus with shd=2'b01 and brit=1 -> RGB=7F,00,00 (shadow wins).
REQ-038 Highlight and transparency: R field=2 (c8=0x10), shd=3, brit=1 -> red=0x87. With col_n=1 -> pal_addr shows 0x000 then 0x001.
REQ-039 Blanking and short period: lhbl=0 with BLANK_ZERO=1 -> RGB=0 and lhbl_dly=0 one pixel later. pxl_cen spacing of 3 clk -> outputs repeat the previous colour, with no corrupted value.
REQ-040 Reset mid-fetch: assert rst at st==1 -> all outputs 0 asynchronously. After release, the first pxl_cen gives 0 and the second gives the fetched colour.
